// File: rtl/mips_mem_pkg.sv
// Shared types and defaults for the instruction/data memory arbiter.
package mips_mem_pkg;

    localparam int unsigned WIDTH_DEF        = 32;
    localparam int unsigned STARVE_LIMIT_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IBUSY = 2'd1,
        DBUSY = 2'd2,
        RESP  = 2'd3
    } state_e;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } gnt_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Core-side request/response and memory-side bus seen by the arbiter.
interface mem_arbiter_if #(
    parameter int unsigned WIDTH = mips_mem_pkg::WIDTH_DEF
);
    logic             if_req;
    logic [WIDTH-1:0] if_adr;
    logic [WIDTH-1:0] if_rdata;
    logic             if_ack;
    logic             d_req;
    logic             d_we;
    logic [WIDTH-1:0] d_adr;
    logic [WIDTH-1:0] d_wdata;
    logic [WIDTH-1:0] d_rdata;
    logic             d_ack;
    logic             mem_req;
    logic             memwrite;
    logic [WIDTH-1:0] dataadr;
    logic [WIDTH-1:0] writedata;
    logic [WIDTH-1:0] mem_rdata;
    logic             mem_ready;
    logic             busy;

    modport slave (
        input  if_req, if_adr, d_req, d_we, d_adr, d_wdata, mem_rdata, mem_ready,
        output if_rdata, if_ack, d_rdata, d_ack, mem_req, memwrite, dataadr, writedata, busy
    );

    modport master (
        output if_req, if_adr, d_req, d_we, d_adr, d_wdata, mem_rdata, mem_ready,
        input  if_rdata, if_ack, d_rdata, d_ack, mem_req, memwrite, dataadr, writedata, busy
    );
endinterface

// File: rtl/mem_arb_prio.sv
// Grant selection (data first) with a saturating counter that forces a
// pending fetch through after STARVE_LIMIT consecutive data grants.
module mem_arb_prio
    import mips_mem_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic arb_en,
    input  logic if_req,
    input  logic d_req,
    output logic gnt_valid_c,
    output gnt_e gnt_c
);

    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] starve_cnt_q;
    logic [CNT_W-1:0] starve_cnt_d;
    logic             starved_c;

    always_comb begin
        starved_c    = if_req && (starve_cnt_q == CNT_W'(STARVE_LIMIT));
        gnt_valid_c  = if_req || d_req;
        gnt_c        = (d_req && !starved_c) ? GNT_D : GNT_I;
        starve_cnt_d = starve_cnt_q;
        if (arb_en && gnt_valid_c) begin
            // Only a data grant that bypasses a waiting fetch counts toward starvation.
            if ((gnt_c == GNT_D) && if_req) begin
                if (starve_cnt_q != CNT_W'(STARVE_LIMIT)) begin
                    starve_cnt_d = starve_cnt_q + CNT_W'(1);
                end
            end else begin
                starve_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store:
// one granted access at a time, registered memory bus and one-cycle acks.
module mem_arbiter
    import mips_mem_pkg::*;
#(
    parameter int unsigned WIDTH        = WIDTH_DEF,
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input logic          clk,
    input logic          reset,
    mem_arbiter_if.slave bus
);

    state_e           state_q, state_d;
    gnt_e             owner_q, owner_d;
    logic             mem_req_q, mem_req_d;
    logic             memwrite_q, memwrite_d;
    logic [WIDTH-1:0] dataadr_q, dataadr_d;
    logic [WIDTH-1:0] writedata_q, writedata_d;
    logic [WIDTH-1:0] if_rdata_q, if_rdata_d;
    logic [WIDTH-1:0] d_rdata_q, d_rdata_d;
    logic             if_ack_q, if_ack_d;
    logic             d_ack_q, d_ack_d;
    logic             busy_q, busy_d;

    logic gnt_valid_c;
    gnt_e gnt_c;

    mem_arb_prio #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_prio (
        .clk         (clk),
        .reset       (reset),
        .arb_en      (state_q == IDLE),
        .if_req      (bus.if_req),
        .d_req       (bus.d_req),
        .gnt_valid_c (gnt_valid_c),
        .gnt_c       (gnt_c)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        mem_req_d   = mem_req_q;
        memwrite_d  = memwrite_q;
        dataadr_d   = dataadr_q;
        writedata_d = writedata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_ack_d    = 1'b0;
        d_ack_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (gnt_valid_c) begin
                    mem_req_d = 1'b1;
                    owner_d   = gnt_c;
                    if (gnt_c == GNT_D) begin
                        state_d     = DBUSY;
                        dataadr_d   = bus.d_adr;
                        writedata_d = bus.d_wdata;
                        memwrite_d  = bus.d_we;
                    end else begin
                        state_d     = IBUSY;
                        dataadr_d   = bus.if_adr;
                        writedata_d = '0;
                        memwrite_d  = 1'b0;
                    end
                end
            end
            IBUSY, DBUSY: begin
                // Bus stays frozen until memory signals completion.
                if (bus.mem_ready) begin
                    state_d    = RESP;
                    mem_req_d  = 1'b0;
                    memwrite_d = 1'b0;
                    if (owner_q == GNT_I) begin
                        if_rdata_d = bus.mem_rdata;
                        if_ack_d   = 1'b1;
                    end else begin
                        if (!memwrite_q) begin
                            d_rdata_d = bus.mem_rdata;
                        end
                        d_ack_d = 1'b1;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= GNT_I;
            mem_req_q   <= 1'b0;
            memwrite_q  <= 1'b0;
            dataadr_q   <= '0;
            writedata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            mem_req_q   <= mem_req_d;
            memwrite_q  <= memwrite_d;
            dataadr_q   <= dataadr_d;
            writedata_q <= writedata_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_ack_q    <= if_ack_d;
            d_ack_q     <= d_ack_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.memwrite  = memwrite_q;
    assign bus.dataadr   = dataadr_q;
    assign bus.writedata = writedata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.if_ack    = if_ack_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.busy      = busy_q;

endmodule
